// File: rtl/cart_header_parser.sv
// Purpose : snoop the ROM download stream and latch the cartridge header fields for the mapper stage.
// Latency : a byte is captured on its ioctl_wr edge; results settle in EVAL, one cycle after the download fall is seen.
// Backpr. : none, one byte per cycle back to back; ioctl_wr outside a download is dropped.
module cart_header_parser (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        header_valid,
    output logic        isGBC_game,
    output logic [7:0]  cart_type,
    output logic [7:0]  rom_size_code,
    output logic [7:0]  ram_size_code,
    output logic [8:0]  rom_mask,
    output logic        checksum_ok,
    output logic        is_sachen,
    output logic        sachen_enable
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_dl_q;
    logic [7:0]  r_acc;
    logic [7:0]  r_hdr_chk;
    logic [7:0]  r_cgb;
    logic        r_lo_bad;
    logic [3:0]  r_hi_seen;
    logic        r_hi_bad;
    logic        r_seen_14f;

    logic        w_rise;
    logic        w_fall;
    logic        w_clear;
    logic        w_cap;
    logic [8:0]  w_a9;
    logic [7:0]  w_logo_byte;
    logic        w_logo_match;
    logic        w_lo_hit;
    logic        w_hi_hit;
    logic        w_sum_hit;
    logic [9:0]  w_mask_full;
    logic        w_is_sachen;

    assign w_rise       = ioctl_download & ~r_dl_q;
    assign w_fall       = ~ioctl_download & r_dl_q;
    assign w_clear      = w_rise & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_cap        = ioctl_wr & (r_state == S_LOAD) & (ioctl_addr[24:9] == 16'h0000);
    assign w_a9         = ioctl_addr[8:0];
    assign w_lo_hit     = w_cap & (w_a9[8:2] == 7'h41);   // 0x104..0x107
    assign w_hi_hit     = w_cap & (w_a9[8:2] == 7'h61);   // 0x184..0x187
    assign w_sum_hit    = w_cap & (w_a9 >= 9'h134) & (w_a9 <= 9'h14C);
    assign w_logo_match = (ioctl_dout == w_logo_byte);
    assign w_mask_full  = (10'd2 << rom_size_code) - 10'd1;
    // The high logo only counts once every one of its four bytes arrived and none mismatched.
    assign w_is_sachen  = r_lo_bad & (&r_hi_seen) & ~r_hi_bad;

    // Expected Nintendo logo prefix byte for the low two address bits.
    always_comb begin
        w_logo_byte = 8'h66;
        case (w_a9[1:0])
            2'd0:    w_logo_byte = 8'hCE;
            2'd1:    w_logo_byte = 8'hED;
            default: w_logo_byte = 8'h66;
        endcase
    end

    // State register and registered copy of the download flag for edge detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_dl_q  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dl_q  <= ioctl_download;
        end
    end

    // Next-state logic: IDLE/DONE wait for a download, LOAD waits for its end, EVAL is one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_fall) w_state_nxt = S_EVAL;
            S_EVAL:  w_state_nxt = S_DONE;
            S_DONE:  if (w_rise) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture during LOAD, evaluate in EVAL, wipe everything when a new download starts.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_acc         <= 8'h00;
            r_hdr_chk     <= 8'h00;
            r_cgb         <= 8'h00;
            r_lo_bad      <= 1'b0;
            r_hi_seen     <= 4'h0;
            r_hi_bad      <= 1'b0;
            r_seen_14f    <= 1'b0;
            cart_type     <= 8'h00;
            rom_size_code <= 8'h00;
            ram_size_code <= 8'h00;
            header_valid  <= 1'b0;
            isGBC_game    <= 1'b0;
            rom_mask      <= 9'h000;
            checksum_ok   <= 1'b0;
            is_sachen     <= 1'b0;
            sachen_enable <= 1'b0;
        end else if (w_clear) begin
            r_acc         <= 8'h00;
            r_hdr_chk     <= 8'h00;
            r_cgb         <= 8'h00;
            r_lo_bad      <= 1'b0;
            r_hi_seen     <= 4'h0;
            r_hi_bad      <= 1'b0;
            r_seen_14f    <= 1'b0;
            cart_type     <= 8'h00;
            rom_size_code <= 8'h00;
            ram_size_code <= 8'h00;
            header_valid  <= 1'b0;
            isGBC_game    <= 1'b0;
            rom_mask      <= 9'h000;
            checksum_ok   <= 1'b0;
            is_sachen     <= 1'b0;
            sachen_enable <= 1'b0;
        end else begin
            if (w_lo_hit && !w_logo_match) r_lo_bad <= 1'b1;
            if (w_hi_hit) begin
                r_hi_seen[w_a9[1:0]] <= 1'b1;
                if (!w_logo_match) r_hi_bad <= 1'b1;
            end
            if (w_sum_hit) r_acc <= r_acc - ioctl_dout - 8'd1;
            if (w_cap) begin
                case (w_a9)
                    9'h143:  r_cgb         <= ioctl_dout;
                    9'h147:  cart_type     <= ioctl_dout;
                    9'h148:  rom_size_code <= ioctl_dout;
                    9'h149:  ram_size_code <= ioctl_dout;
                    9'h14D:  r_hdr_chk     <= ioctl_dout;
                    9'h14F:  r_seen_14f    <= 1'b1;
                    default: ;
                endcase
            end
            if (r_state == S_EVAL) begin
                header_valid  <= r_seen_14f;
                isGBC_game    <= (r_cgb == 8'h80) | (r_cgb == 8'hC0);
                rom_mask      <= (rom_size_code <= 8'd8) ? w_mask_full[8:0] : 9'h1FF;
                checksum_ok   <= (r_acc == r_hdr_chk);
                is_sachen     <= w_is_sachen;
                sachen_enable <= r_seen_14f & w_is_sachen;
            end
        end
    end

endmodule

// File: tb/tb_cart_header_parser.sv
// Purpose : table-driven header images streamed through the parser, results checked from a queue.
// Latency : results compared two cycles after the download fall is sampled.
// Backpr. : none; random single-cycle gaps between writes exercise both paced and back-to-back input.
module tb_cart_header_parser;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        header_valid, isGBC_game, checksum_ok, is_sachen, sachen_enable;
    logic [7:0]  cart_type, rom_size_code, ram_size_code;
    logic [8:0]  rom_mask;

    cart_header_parser dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .header_valid(header_valid), .isGBC_game(isGBC_game), .cart_type(cart_type),
        .rom_size_code(rom_size_code), .ram_size_code(ram_size_code), .rom_mask(rom_mask),
        .checksum_ok(checksum_ok), .is_sachen(is_sachen), .sachen_enable(sachen_enable)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0]  cgb, ctype, rsz, ramsz, chk_add;
        bit          lo_zero, hi_en;
        logic [31:0] hi;
        int          last;
        bit          tail;
        bit          ev, eg;
        logic [8:0]  emask;
        bit          echk, chk_x, es;
    } vec_t;

    typedef struct {
        logic        valid, gbc, chk, chk_x, sachen;
        logic [7:0]  ctype, rsz, ramsz;
        logic [8:0]  mask;
    } exp_t;

    vec_t       vecs [10];
    exp_t       sb [$];
    logic [7:0] rom [0:511];
    int         n_chk = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic build_image(input vec_t v);
        logic [7:0] x;
        for (int a = 0; a < 512; a++) rom[a] = 8'(a) ^ 8'h5A;
        rom[9'h104] = v.lo_zero ? 8'h00 : 8'hCE;
        rom[9'h105] = v.lo_zero ? 8'h00 : 8'hED;
        rom[9'h106] = v.lo_zero ? 8'h00 : 8'h66;
        rom[9'h107] = v.lo_zero ? 8'h00 : 8'h66;
        if (v.hi_en) begin
            rom[9'h184] = v.hi[31:24];
            rom[9'h185] = v.hi[23:16];
            rom[9'h186] = v.hi[15:8];
            rom[9'h187] = v.hi[7:0];
        end
        rom[9'h143] = v.cgb;
        rom[9'h147] = v.ctype;
        rom[9'h148] = v.rsz;
        rom[9'h149] = v.ramsz;
        x = 8'h00;
        for (int a = 'h134; a <= 'h14C; a++) x = x - rom[a] - 8'd1;
        rom[9'h14D] = x + v.chk_add;
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_header_valid"},  32'(header_valid),  32'(e.valid));
        chk({tag, "_isGBC_game"},    32'(isGBC_game),    32'(e.gbc));
        chk({tag, "_cart_type"},     32'(cart_type),     32'(e.ctype));
        chk({tag, "_rom_size_code"}, 32'(rom_size_code), 32'(e.rsz));
        chk({tag, "_ram_size_code"}, 32'(ram_size_code), 32'(e.ramsz));
        chk({tag, "_rom_mask"},      32'(rom_mask),      32'(e.mask));
        if (!e.chk_x) chk({tag, "_checksum_ok"}, 32'(checksum_ok), 32'(e.chk));
        chk({tag, "_is_sachen"},     32'(is_sachen),     32'(e.sachen));
        chk({tag, "_sachen_enable"}, 32'(sachen_enable), 32'(e.valid & e.sachen));
    endtask

    // Stream one header image; optionally check the outputs drop right after the rise is seen.
    task automatic run_vec(input vec_t v, input string tag, input bit chk_rise);
        exp_t e;
        build_image(v);
        e.valid  = v.ev;
        e.gbc    = v.eg;
        e.chk    = v.echk;
        e.chk_x  = v.chk_x;
        e.sachen = v.es;
        e.ctype  = (v.last >= 'h147) ? v.ctype : 8'h00;
        e.rsz    = (v.last >= 'h148) ? v.rsz   : 8'h00;
        e.ramsz  = (v.last >= 'h149) ? v.ramsz : 8'h00;
        e.mask   = v.emask;
        sb.push_back(e);
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        if (chk_rise) begin
            chk({tag, "_rise_sachen_enable"}, 32'(sachen_enable), 32'd0);
            chk({tag, "_rise_header_valid"},  32'(header_valid),  32'd0);
        end
        for (int a = 'h100; a <= v.last; a++) begin
            if (v.tail && a == 'h14D) continue;
            ioctl_wr = 1'b1;
            ioctl_addr = 25'(a);
            ioctl_dout = rom[a];
            @(negedge clk_sys);
            if ($urandom_range(0, 7) == 0) begin
                ioctl_wr = 1'b0;
                @(negedge clk_sys);
            end
        end
        if (v.tail) begin
            ioctl_wr = 1'b1;
            ioctl_addr = 25'h14D;
            ioctl_dout = rom[9'h14D];
        end else begin
            ioctl_wr = 1'b0;
        end
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check_outputs(tag);
    endtask

    initial begin
        //            cgb    ctype  rsz    ramsz  add   lo hi hi_word        last    tl ev eg emask   echk x  es
        vecs[0] = '{8'h00, 8'h01, 8'h05, 8'h00, 8'h0, 0, 0, 32'h0,         'h1FF, 0, 1, 0, 9'h03F, 1, 0, 0};
        vecs[1] = '{8'h00, 8'h01, 8'h04, 8'h00, 8'h0, 1, 1, 32'hCEED6666,  'h1FF, 0, 1, 0, 9'h01F, 1, 0, 1};
        vecs[2] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h0, 1, 1, 32'hCEED6667,  'h1FF, 0, 1, 0, 9'h001, 1, 0, 0};
        vecs[3] = '{8'hC0, 8'h1B, 8'h06, 8'h03, 8'h0, 0, 0, 32'h0,         'h1FF, 0, 1, 1, 9'h07F, 1, 0, 0};
        vecs[4] = '{8'h80, 8'h1B, 8'h08, 8'h02, 8'h0, 0, 0, 32'h0,         'h1FF, 0, 1, 1, 9'h1FF, 1, 0, 0};
        vecs[5] = '{8'hC0, 8'h1B, 8'h06, 8'h03, 8'h1, 0, 0, 32'h0,         'h1FF, 0, 1, 1, 9'h07F, 0, 0, 0};
        vecs[6] = '{8'h80, 8'h01, 8'h05, 8'h00, 8'h0, 1, 0, 32'h0,         'h140, 0, 0, 0, 9'h001, 0, 1, 0};
        vecs[7] = '{8'h00, 8'h00, 8'h52, 8'h00, 8'h0, 0, 0, 32'h0,         'h1FF, 0, 1, 0, 9'h1FF, 1, 0, 0};
        vecs[8] = '{8'h00, 8'h00, 8'h09, 8'h01, 8'h0, 0, 0, 32'h0,         'h1FF, 0, 1, 0, 9'h1FF, 1, 0, 0};
        vecs[9] = '{8'h00, 8'h01, 8'h05, 8'h00, 8'h0, 0, 0, 32'h0,         'h1FF, 1, 1, 0, 9'h03F, 1, 0, 0};

        repeat (3) @(negedge clk_sys);
        chk("rst_header_valid",  32'(header_valid),  32'd0);
        chk("rst_sachen_enable", 32'(sachen_enable), 32'd0);
        chk("rst_fields", 32'({isGBC_game, cart_type, rom_size_code, ram_size_code, rom_mask, checksum_ok, is_sachen}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // Reset in the middle of a download after a CGB result is already latched.
        run_vec(vecs[3], "pre_rst", 1'b0);
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b1; ioctl_addr = 25'h143; ioctl_dout = 8'hC0;
        @(negedge clk_sys);
        ioctl_addr = 25'h147; ioctl_dout = 8'h1B;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("midrst_header_valid",  32'(header_valid),  32'd0);
        chk("midrst_sachen_enable", 32'(sachen_enable), 32'd0);
        chk("midrst_fields", 32'({isGBC_game, cart_type, rom_size_code, ram_size_code, rom_mask, checksum_ok, is_sachen}), 32'd0);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        chk("midrst_held_fields", 32'({header_valid, isGBC_game, cart_type, rom_mask, sachen_enable}), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        run_vec(vecs[0], "post_rst", 1'b0);

        // Sachen result, then a DMG re-download must drop sachen_enable as soon as the rise is seen.
        run_vec(vecs[1], "sachen_again", 1'b0);
        run_vec(vecs[0], "redl_dmg", 1'b1);

        repeat (2) @(negedge clk_sys);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cart_header_parser.md
# cart_header_parser

Snoops the cartridge ROM download stream and extracts the header fields the mapper stage needs before the CPU leaves reset: CGB flag, cartridge type, ROM/RAM size codes, header checksum status, and Sachen detection. It sits directly upstream of the mapper bank (including the Sachen mapper), driving `isGBC_game` and the per-mapper `enable` lines. All outputs are registered and stay stable for the whole run after a download completes.

## Interface
- No parameters.
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: high for the whole ROM download.
- `ioctl_wr` in 1: one-cycle strobe per valid byte.
- `ioctl_addr` in 25: byte address of `ioctl_dout`.
- `ioctl_dout` in 8: download data byte.
- `header_valid` out 1: header fully received and results latched.
- `isGBC_game` out 1: byte 0x143 is 0x80 or 0xC0.
- `cart_type` out 8: byte 0x147.
- `rom_size_code` out 8: byte 0x148.
- `ram_size_code` out 8: byte 0x149.
- `rom_mask` out 9: 16 KB bank mask, equal to (2 << rom_size_code) − 1 for codes 0..8, otherwise 0x1FF.
- `checksum_ok` out 1: computed header checksum equals byte 0x14D.
- `is_sachen` out 1: Sachen logo signature detected.
- `sachen_enable` out 1: `header_valid & is_sachen`; drives the Sachen mapper `enable`.

## Operation
- Reset state is IDLE. At reset, every output and internal register is 0.
- FSM states:
  - IDLE: a rising edge of `ioctl_download` goes to LOAD. The rising edge also clears all capture registers, flags and the checksum accumulator, and drops `header_valid` and `sachen_enable` in that same cycle.
  - LOAD: captures bytes on each `ioctl_wr` (rules below). A falling edge of `ioctl_download` goes to EVAL.
  - EVAL: lasts one cycle. Computes `rom_mask`, `checksum_ok`, `is_sachen` and `header_valid`, then goes to DONE.
  - DONE: all outputs are held. A new rising edge of `ioctl_download` clears everything and re-enters LOAD.
- Capture rules, applied only on `ioctl_wr` in LOAD, with `ioctl_addr[24:9] == 0`:
  - 0x0104–0x0107: compared against CE ED 66 66. Any mismatch sets `logo_lo_bad`.
  - 0x0184–0x0187: compared against CE ED 66 66. Sets `logo_hi_ok` if all four bytes match; any mismatch clears it for good in this download.
  - 0x0134–0x014C: checksum accumulator `acc <= acc - byte - 1`, 8-bit, wraps modulo 256.
  - 0x0143, 0x0147, 0x0148, 0x0149, 0x014D: latched into their registers.
  - `seen_14F` is set when address 0x014F is written.
- Results computed in EVAL:
  - `header_valid = seen_14F`. A truncated download leaves it 0, and then `sachen_enable` = 0.
  - `checksum_ok = (acc == hdr_chk)`.
  - `is_sachen = logo_lo_bad & logo_hi_ok`. The 0x184 match requires all four bytes to have been received.
  - `isGBC_game = (cgb == 0x80) | (cgb == 0xC0)`.
- Bytes may arrive out of order or be rewritten:
  - Latched fields take the last write.
  - The checksum is only correct for a single in-order pass. Rewriting 0x134–0x14C is undefined for `checksum_ok` only.
- `ioctl_wr` outside LOAD is ignored.

## Timing
- Capture is registered in the same edge as `ioctl_wr`, with no back-pressure. The block accepts one byte per cycle, back to back.
- Download edges are detected with a registered copy of `ioctl_download`, so each edge is seen one cycle late.
- Outputs become valid 2 cycles after the first clock where `ioctl_download` is sampled low: one cycle for edge detection, one cycle for EVAL.
- `sachen_enable` and `isGBC_game` change only in EVAL or on a download rising edge, so they are glitch-free toward the mapper.
- If `ioctl_wr` and the falling edge of `ioctl_download` arrive in the same cycle, the byte is still captured.
- If `reset_n` is asserted mid-LOAD, the block returns to IDLE with all outputs 0. The next download rise restarts cleanly.

## Test plan
- **Standard DMG ROM:** header has 0x143=0x00, 0x147=0x01, 0x148=0x05, 0x149=0x00, with a correct 0x14D. Require `header_valid`=1, `isGBC_game`=0, `cart_type`=0x01, `rom_mask`=0x03F, `checksum_ok`=1 and `sachen_enable`=0, all 2 cycles after the download falls.
- **Sachen MMC1 image:** 0x104 = 00 00 00 00 and 0x184 = CE ED 66 66. Require `is_sachen`=1 and `sachen_enable`=1. A second variant with 0x187=0x67 requires `is_sachen`=0.
- **CGB flag and checksum:** 0x143=0xC0, then 0x143=0x80, give `isGBC_game`=1 in both cases. Corrupting 0x14D by +1 gives `checksum_ok`=0; all other outputs are unchanged.
- **Truncation and out-of-range size:** a download ending at address 0x0140 gives `header_valid`=0 and `sachen_enable`=0. A separate run with 0x148=0x52 gives `rom_mask`=0x1FF.
- **Reset and re-download:** assert `reset_n` low mid-LOAD and check all outputs are 0 while it is held. After a full Sachen load reaches DONE, start a new DMG download: `sachen_enable` must drop on the first cycle the rise is detected and stay 0 after EVAL.
- **Boundary write:** the 0x14D byte written in the same cycle `ioctl_download` falls is still captured, and `checksum_ok`=1.
